// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the five-stage pipeline hazard
// controller.
//   sb_entry_t          - one scoreboard slot {valid, rd, regwrite, load}
//   FWD_REG/MEM/WB      - ALU operand mux selects
//   NOP_INSN            - encoding loaded into ir1 on a flush (addi x0,x0,0)
package pipe_pkg;

    localparam int SB_RAW = 5;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef struct packed {
        logic              valid;
        logic [SB_RAW-1:0] rd;
        logic              regwrite;
        logic              load;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '0;

endpackage

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: three-entry in-flight write tracker covering EX, MEM, WB.
// Entries advance every cycle; the EX slot takes the decode entry when it
// issues, otherwise an empty slot. Produces per-source match vectors
// (bit 0 = EX, bit 1 = MEM, bit 2 = WB).
//   clk_i, reset_i      - clock, synchronous active-low reset
//   issue_i, id_entry_i - decode instruction entering EX this cycle
//   rs*_i, use_rs*_i    - decode sources to match against
//   match*_o            - per-stage hits for rs1 / rs2
//   *_valid_o, ex_load_o- stage occupancy, EX entry is a load
import pipe_pkg::*;

module pipe_scoreboard #(
    parameter int RAW = 5
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           issue_i,
    input  sb_entry_t      id_entry_i,
    input  logic [RAW-1:0] rs1_i,
    input  logic [RAW-1:0] rs2_i,
    input  logic           use_rs1_i,
    input  logic           use_rs2_i,
    output logic [2:0]     match1_o,
    output logic [2:0]     match2_o,
    output logic           ex_valid_o,
    output logic           mem_valid_o,
    output logic           wb_valid_o,
    output logic           ex_load_o
);

    sb_entry_t ex_q, mem_q, wb_q, ex_d;

    assign ex_d = issue_i ? id_entry_i : SB_EMPTY;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            ex_q  <= SB_EMPTY;
            mem_q <= SB_EMPTY;
            wb_q  <= SB_EMPTY;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    // x0 never matches: it is neither a real source nor a real destination.
    function automatic logic hit(sb_entry_t e, logic [RAW-1:0] src, logic use_src);
        return use_src && (src != '0) && e.valid && e.regwrite && (e.rd == src);
    endfunction

    assign match1_o = {hit(wb_q, rs1_i, use_rs1_i), hit(mem_q, rs1_i, use_rs1_i),
                       hit(ex_q, rs1_i, use_rs1_i)};
    assign match2_o = {hit(wb_q, rs2_i, use_rs2_i), hit(mem_q, rs2_i, use_rs2_i),
                       hit(ex_q, rs2_i, use_rs2_i)};

    assign ex_valid_o  = ex_q.valid;
    assign mem_valid_o = mem_q.valid;
    assign wb_valid_o  = wb_q.valid;
    assign ex_load_o   = ex_q.load;

    // The load flag only matters in EX; past that it simply rides along.
    logic unused_wb_load;
    assign unused_wb_load = wb_q.load;

endmodule

// File: rtl/pipeline_controller.sv
// pipeline_controller: stall / bubble / flush sequencing and ALU forwarding
// selects for the five-stage CPU.
//   clk_i, reset_i        - clock, synchronous active-low reset
//   id_*_i                - decode-stage instruction fields
//   br_taken_i            - EX-stage instruction redirects the PC
//   stall_o, flush_o      - combinational hold / kill controls
//   bubble_o, fwd_sel*_o  - registered, aligned with EX
//   *_valid_o             - stage occupancy
//   stall_cnt_o/flush_cnt_o - saturating event counters
// Build option: PIPE_FORWARD_EN compiles in the MEM/WB bypass selection;
// without it every in-flight dependency stalls until the producer retires.
import pipe_pkg::*;

module pipeline_controller #(
    parameter int XLEN = 32,
    parameter int RAW  = 5
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            id_valid_i,
    input  logic [RAW-1:0]  id_rs1_i,
    input  logic [RAW-1:0]  id_rs2_i,
    input  logic            id_use_rs1_i,
    input  logic            id_use_rs2_i,
    input  logic [RAW-1:0]  id_rd_i,
    input  logic            id_regwrite_i,
    input  logic            id_load_i,
    input  logic            br_taken_i,
    output logic            stall_o,
    output logic            bubble_o,
    output logic            flush_o,
    output logic [1:0]      fwd_sel1_o,
    output logic [1:0]      fwd_sel2_o,
    output logic            ex_valid_o,
    output logic            mem_valid_o,
    output logic            wb_valid_o,
    output logic [XLEN-1:0] stall_cnt_o,
    output logic [XLEN-1:0] flush_cnt_o
);

    sb_entry_t       id_entry;
    logic [1:0][2:0] match;      // [source][stage]
    logic [2:0]      match1, match2;
    logic            ex_load, hazard, issue;
    logic [1:0]      src_stall;
    logic [1:0][1:0] src_sel;

    logic            bubble_q, bubble_d;
    logic [1:0]      fwd1_q, fwd1_d, fwd2_q, fwd2_d;
    logic [XLEN-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    assign id_entry = '{valid: 1'b1, rd: id_rd_i, regwrite: id_regwrite_i, load: id_load_i};

    pipe_scoreboard #(.RAW(RAW)) u_sb (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .issue_i    (issue),
        .id_entry_i (id_entry),
        .rs1_i      (id_rs1_i),
        .rs2_i      (id_rs2_i),
        .use_rs1_i  (id_use_rs1_i),
        .use_rs2_i  (id_use_rs2_i),
        .match1_o   (match1),
        .match2_o   (match2),
        .ex_valid_o (ex_valid_o),
        .mem_valid_o(mem_valid_o),
        .wb_valid_o (wb_valid_o),
        .ex_load_o  (ex_load)
    );

    assign match = {match2, match1};

    // Per-source resolution; youngest producer (EX) takes precedence.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            src_stall[s] = 1'b0;
            src_sel[s]   = FWD_REG;
`ifdef PIPE_FORWARD_EN
            if (match[s][0]) begin
                // Load data is not available until MEM completes.
                if (ex_load) src_stall[s] = 1'b1;
                else         src_sel[s]   = FWD_MEM;
            end else if (match[s][1]) begin
                src_sel[s] = FWD_WB;
            end else if (match[s][2]) begin
                // No bypass from a retiring WB value; wait for the bank write.
                src_stall[s] = 1'b1;
            end
`else
            src_stall[s] = |match[s];
`endif
        end
    end

`ifndef PIPE_FORWARD_EN
    logic unused_ex_load;
    assign unused_ex_load = ex_load;
`endif

    assign hazard  = id_valid_i & (|src_stall);
    assign flush_o = br_taken_i & ex_valid_o;
    // A flush kills the decode instruction, so there is nothing left to hold.
    assign stall_o = hazard & ~flush_o;
    assign issue   = id_valid_i & ~stall_o & ~flush_o;

    assign bubble_d    = ~issue;
    assign fwd1_d      = issue ? src_sel[0] : FWD_REG;
    assign fwd2_d      = issue ? src_sel[1] : FWD_REG;
    assign stall_cnt_d = (stall_o && stall_cnt_q != {XLEN{1'b1}}) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    assign flush_cnt_d = (flush_o && flush_cnt_q != {XLEN{1'b1}}) ? flush_cnt_q + 1'b1 : flush_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            bubble_q    <= 1'b0;
            fwd1_q      <= FWD_REG;
            fwd2_q      <= FWD_REG;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            bubble_q    <= bubble_d;
            fwd1_q      <= fwd1_d;
            fwd2_q      <= fwd2_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bubble_o    = bubble_q;
    assign fwd_sel1_o  = fwd1_q;
    assign fwd_sel2_o  = fwd2_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Bench for pipeline_controller. The reference model tracks issued
// instructions by issue cycle: age 1/2/3 cycles means EX/MEM/WB. Counters are
// narrowed so saturation is reachable.
module tb_pipeline_controller;

    localparam int XLEN = 4;
    localparam int RAW  = 5;
    localparam int CMAX = (1 << XLEN) - 1;

    logic clk = 1'b0, reset = 1'b0;
    logic id_valid = 0, id_use_rs1 = 0, id_use_rs2 = 0, id_regwrite = 0, id_load = 0, br_taken = 0;
    logic [RAW-1:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0;
    logic stall, bubble, flush, ex_valid, mem_valid, wb_valid;
    logic [1:0] fwd_sel1, fwd_sel2;
    logic [XLEN-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipeline_controller #(.XLEN(XLEN), .RAW(RAW)) dut (
        .clk_i(clk), .reset_i(reset), .id_valid_i(id_valid),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
        .id_rd_i(id_rd), .id_regwrite_i(id_regwrite), .id_load_i(id_load), .br_taken_i(br_taken),
        .stall_o(stall), .bubble_o(bubble), .flush_o(flush),
        .fwd_sel1_o(fwd_sel1), .fwd_sel2_o(fwd_sel2),
        .ex_valid_o(ex_valid), .mem_valid_o(mem_valid), .wb_valid_o(wb_valid),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int cyc; int rd; bit rw; bit ld; } rec_t;
    rec_t q[$];
    int cyc = 0;
    bit bub_m = 0;
    int f1_m = 0, f2_m = 0, sc_m = 0, fc_m = 0;

    function automatic void youngest(input int src, output int age, output bit ld);
        age = 0; ld = 0;
        foreach (q[i]) begin
            int a = cyc - q[i].cyc;
            if (q[i].rw && q[i].rd == src && a >= 1 && a <= 3 && (age == 0 || a < age)) begin
                age = a; ld = q[i].ld;
            end
        end
    endfunction

    function automatic void src_eval(input bit u, input int src, output bit st, output int sel);
        int age; bit ld;
        st = 0; sel = 0;
        if (!u || src == 0) return;
        youngest(src, age, ld);
`ifdef PIPE_FORWARD_EN
        case (age)
            1: if (ld) st = 1; else sel = 1;
            2: sel = 2;
            3: st = 1;
            default: ;
        endcase
`else
        st = (age != 0);
`endif
    endfunction

    function automatic bit stage_valid(input int a);
        foreach (q[i]) if (cyc - q[i].cyc == a) return 1;
        return 0;
    endfunction

    function automatic void model(output bit st, output bit fl, output int s1, output int s2, output bit iss);
        bit a, b;
        src_eval(id_use_rs1, int'(id_rs1), a, s1);
        src_eval(id_use_rs2, int'(id_rs2), b, s2);
        fl  = br_taken && stage_valid(1);
        st  = id_valid && (a || b) && !fl;
        iss = id_valid && !st && !fl;
    endfunction

    // Compare on every falling edge, then advance the model to the state the
    // next rising edge produces (inputs are stable until after that edge).
    initial begin
        bit st, fl, iss;
        int s1, s2;
        forever begin
            @(negedge clk);
            model(st, fl, s1, s2, iss);
            chk("stall", stall, st);
            chk("flush", flush, fl);
            chk("bubble", bubble, bub_m);
            chk("fwd_sel1", fwd_sel1, f1_m);
            chk("fwd_sel2", fwd_sel2, f2_m);
            chk("ex_valid", ex_valid, stage_valid(1));
            chk("mem_valid", mem_valid, stage_valid(2));
            chk("wb_valid", wb_valid, stage_valid(3));
            chk("stall_cnt", stall_cnt, sc_m);
            chk("flush_cnt", flush_cnt, fc_m);
            if (!reset) begin
                q.delete(); bub_m = 0; f1_m = 0; f2_m = 0; sc_m = 0; fc_m = 0;
            end else begin
                if (st && sc_m < CMAX) sc_m++;
                if (fl && fc_m < CMAX) fc_m++;
                bub_m = !iss;
                f1_m  = iss ? s1 : 0;
                f2_m  = iss ? s2 : 0;
                if (iss) q.push_back('{cyc, int'(id_rd), id_regwrite, id_load});
                cyc++;
                while (q.size() > 0 && cyc - q[0].cyc > 3) void'(q.pop_front());
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_regwrite = 0; id_load = 0;
        br_taken = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        repeat (n) step();
    endtask

    // Present one instruction in decode and hold it until it issues.
    task automatic send(input int rd, input bit rw, input bit ld, input int r1, input bit u1,
                        input int r2, input bit u2, output int nst);
        bit st, fl, iss; int s1, s2;
        id_valid = 1; id_rd = RAW'(rd); id_regwrite = rw; id_load = ld;
        id_rs1 = RAW'(r1); id_use_rs1 = u1; id_rs2 = RAW'(r2); id_use_rs2 = u2;
        nst = 0;
        model(st, fl, s1, s2, iss);
        while (st) begin
            if (nst >= 8) begin
                chk("stall_timeout", nst, 0);
                break;
            end
            step();
            nst++;
            chk("stall_bubble", bubble, 1);
            model(st, fl, s1, s2, iss);
        end
        step();
        id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_regwrite = 0; id_load = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset with random decode/branch inputs.
        reset = 0;
        repeat (2) begin
            id_valid = 1'($urandom); id_rs1 = RAW'($urandom); id_rs2 = RAW'($urandom);
            id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom); id_rd = RAW'($urandom);
            id_regwrite = 1'($urandom); id_load = 1'($urandom); br_taken = 1'($urandom);
            step();
        end
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_bubble", bubble, 0);
        chk("rst_fwd", {fwd_sel1, fwd_sel2}, 0);
        chk("rst_cnt", {stall_cnt, flush_cnt}, 0);
        idle(0);
        reset = 1;
        idle(1);

        // add x5 ; sub x7,x5,x6
        send(5, 1, 0, 0, 0, 0, 0, n);
        send(7, 1, 0, 5, 1, 6, 1, n);
`ifdef PIPE_FORWARD_EN
        chk("raw_stalls", n, 0);
        chk("raw_fwd1", fwd_sel1, 1);
`else
        chk("raw_stalls", n, 3);
        chk("raw_stall_cnt", stall_cnt, 3);
        chk("raw_fwd1", fwd_sel1, 0);
`endif
        idle(4);

        // addi x1 ; addi x2,x1 ; add x3,x1,x2
        send(1, 1, 0, 0, 0, 0, 0, n);
        send(2, 1, 0, 1, 1, 0, 0, n);
`ifdef PIPE_FORWARD_EN
        chk("chain2_stalls", n, 0);
        chk("chain2_fwd1", fwd_sel1, 1);
`else
        chk("chain2_stalls", n, 3);
`endif
        send(3, 1, 0, 1, 1, 2, 1, n);
`ifdef PIPE_FORWARD_EN
        chk("chain3_stalls", n, 0);
        chk("chain3_fwd1", fwd_sel1, 2);
        chk("chain3_fwd2", fwd_sel2, 1);
`else
        chk("chain3_stalls", n, 3);
        chk("chain3_fwd", {fwd_sel1, fwd_sel2}, 0);
`endif
        idle(4);

        // lw x4 ; add x6,x4,x0
        send(4, 1, 1, 0, 0, 0, 0, n);
        send(6, 1, 0, 4, 1, 0, 1, n);
`ifdef PIPE_FORWARD_EN
        chk("lu_stalls", n, 1);
        chk("lu_fwd1", fwd_sel1, 2);
`else
        chk("lu_stalls", n, 3);
`endif
        chk("lu_fwd2", fwd_sel2, 0);
        idle(1);

        // Reset mid-operation with work in flight.
        send(8, 1, 0, 0, 0, 0, 0, n);
        reset = 0;
        step();
        reset = 1;
        chk("mid_rst_valid", {ex_valid, mem_valid, wb_valid}, 0);
        chk("mid_rst_cnt", {stall_cnt, flush_cnt}, 0);
        idle(1);

        // Branch in EX while decode waits on it: flush wins.
        send(5, 1, 1, 0, 0, 0, 0, n);
        id_valid = 1; id_rd = 9; id_regwrite = 1; id_rs1 = 5; id_use_rs1 = 1;
        br_taken = 1;
        #1;
        chk("br_flush", flush, 1);
        chk("br_stall", stall, 0);
        step();
        br_taken = 0; id_valid = 0; id_use_rs1 = 0;
        chk("br_dropped", ex_valid, 0);
        chk("br_bubble", bubble, 1);
        chk("br_flush_cnt", flush_cnt, 1);
        chk("br_stall_cnt", stall_cnt, 0);
        idle(4);

        // x0 dependency.
        send(0, 1, 0, 0, 0, 0, 0, n);
        send(10, 1, 0, 0, 1, 0, 1, n);
        chk("x0_stalls", n, 0);
        chk("x0_fwd", {fwd_sel1, fwd_sel2}, 0);
        idle(4);

        // WB-distance dependency repeated until the stall counter saturates.
        for (int i = 0; i < 20; i++) begin
            send(9, 1, 0, 0, 0, 0, 0, n);
            send(10, 1, 0, 0, 0, 0, 0, n);
            send(11, 1, 0, 0, 0, 0, 0, n);
            send(12, 1, 0, 9, 1, 0, 0, n);
            chk("wb_stall", n, 1);
        end
        chk("sat_stall_cnt", stall_cnt, CMAX);
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
